// File: rtl/nubus_arbiter_seq_if.sv
// Master-engine side of the NuBus arbiter: request/lock in, ownership and bus status out.
interface nubus_arbiter_seq_if;
   logic mst_req;
   logic mst_lock;
   logic grant;
   logic arb_active;
   logic bus_busy;

   modport master (
      output mst_req,
      output mst_lock,
      input  grant,
      input  arb_active,
      input  bus_busy
   );

   modport slave (
      input  mst_req,
      input  mst_lock,
      output grant,
      output arb_active,
      output bus_busy
   );
endinterface

// File: rtl/nubus_arbiter_seq.sv
// Clocked NuBus arbitration controller: RQST/ARB sequencing, settle timer, tenure tracking,
// fairness and locked tenures. Idle-bus latency mst_req -> grant is SETTLE+2 clocks.
module nubus_arbiter_seq #(
   parameter int ARB_WIDTH = 4,
   parameter int SETTLE    = 2,
   parameter bit FAIR      = 1'b1
) (
   input  logic                 nub_clkn,
   input  logic                 nub_resetn,
   input  logic [ARB_WIDTH-1:0] nub_idn,
   inout  wire  [ARB_WIDTH-1:0] nub_arbn,
   inout  wire                  nub_rqstn,
   input  logic                 nub_startn,
   input  logic                 nub_ackn,
   nubus_arbiter_seq_if.slave   mst
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_WON,
      ST_LOST,
      ST_OWN
   } state_t;

   state_t               state;
   logic [3:0]           cnt;
   logic                 grant_q;
   logic                 arb_active_q;
   logic                 rqst_drv_q;
   logic                 bus_busy_q;
   logic                 fair_block;
   logic [ARB_WIDTH:0]   blk;
   logic [ARB_WIDTH-1:0] part;
   logic                 win;

   // blk[i] is set once some bit at or above i shows another card with a 1 where our ID has a 0.
   assign blk[ARB_WIDTH] = 1'b0;
   for (genvar g = 0; g < ARB_WIDTH; g++) begin : g_contest
      assign blk[g]      = blk[g+1] | (nub_idn[g] & ~nub_arbn[g]);
      assign part[g]     = arb_active_q & ~nub_idn[g] & ~blk[g+1];
      assign nub_arbn[g] = part[g] ? 1'b0 : 1'bz;
   end

   assign win       = arb_active_q & ~blk[0];
   assign nub_rqstn = rqst_drv_q ? 1'b0 : 1'bz;

   always_ff @(posedge nub_clkn or negedge nub_resetn) begin
      if (!nub_resetn) begin
         state        <= ST_IDLE;
         cnt          <= 4'd0;
         grant_q      <= 1'b0;
         arb_active_q <= 1'b0;
         rqst_drv_q   <= 1'b0;
         bus_busy_q   <= 1'b0;
         fair_block   <= 1'b0;
      end else begin
         if (!nub_startn && nub_ackn) begin
            bus_busy_q <= 1'b1;
         end else if (nub_startn && !nub_ackn) begin
            bus_busy_q <= 1'b0;
         end

         // A later set from the OWN exit below takes precedence over this clear.
         if (FAIR && nub_rqstn) begin
            fair_block <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (mst.mst_req && !fair_block) begin
                  state        <= ST_ARB;
                  cnt          <= 4'(SETTLE);
                  arb_active_q <= 1'b1;
                  rqst_drv_q   <= 1'b1;
               end
            end
            ST_ARB: begin
               if (!mst.mst_req) begin
                  state        <= ST_IDLE;
                  cnt          <= 4'd0;
                  grant_q      <= 1'b0;
                  arb_active_q <= 1'b0;
                  rqst_drv_q   <= 1'b0;
               end else begin
                  cnt <= cnt - 4'd1;
                  if (cnt == 4'd1) begin
                     if (win) begin
                        state <= ST_WON;
                     end else begin
                        state        <= ST_LOST;
                        arb_active_q <= 1'b0;
                     end
                  end
               end
            end
            ST_WON: begin
               if (!bus_busy_q && nub_startn) begin
                  state        <= ST_OWN;
                  grant_q      <= 1'b1;
                  arb_active_q <= 1'b0;
                  rqst_drv_q   <= 1'b0;
               end
            end
            ST_LOST: begin
               if (!mst.mst_req) begin
                  state        <= ST_IDLE;
                  cnt          <= 4'd0;
                  grant_q      <= 1'b0;
                  arb_active_q <= 1'b0;
                  rqst_drv_q   <= 1'b0;
               end else if (!nub_startn) begin
                  state        <= ST_ARB;
                  cnt          <= 4'(SETTLE);
                  arb_active_q <= 1'b1;
               end
            end
            ST_OWN: begin
               if (!mst.mst_req && !mst.mst_lock) begin
                  state        <= ST_IDLE;
                  cnt          <= 4'd0;
                  grant_q      <= 1'b0;
                  arb_active_q <= 1'b0;
                  rqst_drv_q   <= 1'b0;
                  if (FAIR) begin
                     fair_block <= 1'b1;
                  end
               end
            end
            default: begin
               state        <= ST_IDLE;
               cnt          <= 4'd0;
               grant_q      <= 1'b0;
               arb_active_q <= 1'b0;
               rqst_drv_q   <= 1'b0;
            end
         endcase
      end
   end

   assign mst.grant      = grant_q;
   assign mst.arb_active = arb_active_q;
   assign mst.bus_busy   = bus_busy_q;

endmodule
